// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Holds the segment bit positions within a 7-bit g..a segment word and the
// 16-entry hex-to-segment table in active-high form (bit set = segment lit).
package seg_pkg;

    localparam int unsigned SEG_W = 7;

    // Bit position of each segment inside a {g,f,e,d,c,b,a} word
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Glyphs 0-9, A, b, C, d, E, F; every value lights at least one segment
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment decoder, active-high output.
// Ports:
//   i_nibble  4-bit hex value
//   o_seg_c   segments {g,f,e,d,c,b,a}, 1 = lit (combinational)
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_seg_c
);

    assign o_seg_c = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment display scanner.
// A free-running prescaler produces a scan tick every 2^DIV_BITS clocks; each
// tick presents one digit slot (digit enable, segments and dp change together).
// Loaded values sit in a pending register and are promoted to the displayed
// register only at the start of a frame, so a frame never mixes two values.
// Optional feature: define SEG_BLINK_EN to enable per-digit blinking driven by
// a 2^(DIV_BITS+8)-cycle counter; when undefined, blink_mask is ignored.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   nums        hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   load        capture strobe for nums/dp_in
//   dp_in       per-digit decimal point request
//   blank_mask  1 = digit forced dark (live)
//   lz_en       leading-zero suppression enable (live)
//   blink_mask  per-digit blink request (SEG_BLINK_EN only)
//   display     segments g..a (registered)
//   dp          decimal point (registered)
//   digit       one-hot digit enables (registered)
//   frame       one-cycle pulse when the scan returns to digit 0
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV_BITS   = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] nums,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [SEG_W-1:0]        display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned NUM_W   = 4 * NUM_DIGITS;
    localparam int unsigned BLINK_W = DIV_BITS + 8;

    logic [DIV_BITS-1:0]   r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_W-1:0]      r_pend_nums;
    logic [NUM_W-1:0]      r_act_nums;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [SEG_W-1:0]      r_display;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_digit;
    logic                  r_frame;

    logic                  w_tick;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NUM_W-1:0]      w_act_nums;
    logic [NUM_DIGITS-1:0] w_act_dp;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic [IDX_W-1:0]      w_hi;
    logic                  w_blink_dark;
    logic                  w_lit;
    logic [SEG_W-1:0]      w_seg_c;
    logic [NUM_DIGITS-1:0] w_dig_on;

    // Prescaler: tick on the all-ones count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_div <= '0;
        else     r_div <= r_div + DIV_BITS'(1);
    end

    assign w_tick = &r_div;

    // r_idx is the slot presented at the next tick; presenting slot 0 starts a frame
    assign w_wrap     = w_tick & (r_idx == '0);
    assign w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_idx <= '0;
        else if (w_tick) r_idx <= w_idx_next;
    end

    // Value in effect for this cycle's tick; a load coincident with the frame start wins
    assign w_act_nums = w_wrap ? (load ? nums  : r_pend_nums) : r_act_nums;
    assign w_act_dp   = w_wrap ? (load ? dp_in : r_pend_dp)   : r_act_dp;

    // Pending and displayed data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_nums <= '0;
            r_pend_dp   <= '0;
            r_act_nums  <= '0;
            r_act_dp    <= '0;
        end else begin
            if (load) begin
                r_pend_nums <= nums;
                r_pend_dp   <= dp_in;
            end
            if (w_wrap) begin
                r_act_nums <= w_act_nums;
                r_act_dp   <= w_act_dp;
            end
        end
    end

    // Select the presented slot and find the highest nonzero nibble
    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_hi        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = w_act_nums[4*i +: 4];
                w_dp_sel    = w_act_dp[i];
                w_blank_sel = blank_mask[i];
            end
            if (w_act_nums[4*i +: 4] != 4'h0) w_hi = IDX_W'(i);
        end
    end

`ifdef SEG_BLINK_EN
    logic [BLINK_W-1:0] r_blink;
    logic               w_blink_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_blink <= '0;
        else     r_blink <= r_blink + BLINK_W'(1);
    end

    always_comb begin
        w_blink_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) w_blink_sel = blink_mask[i];
        end
    end

    assign w_blink_dark = r_blink[BLINK_W-1] & w_blink_sel;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink_dark   = 1'b0;
`endif

    seg_hex_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg_c  (w_seg_c)
    );

    // Digit 0 is never above w_hi, so an all-zero value still shows one "0"
    assign w_lit = ~w_blank_sel & ~(lz_en & (r_idx > w_hi)) & ~w_blink_dark;

    always_comb begin
        w_dig_on = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_dig_on[i] = w_lit & (r_idx == IDX_W'(i));
        end
    end

    // Output registers, polarity applied here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display <= {SEG_W{ACTIVE_LOW}};
            r_dp      <= ACTIVE_LOW;
            r_digit   <= {NUM_DIGITS{ACTIVE_LOW}};
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_tick) begin
                r_display <= (w_lit ? w_seg_c : '0) ^ {SEG_W{ACTIVE_LOW}};
                r_dp      <= (w_lit & w_dp_sel) ^ ACTIVE_LOW;
                r_digit   <= w_dig_on ^ {NUM_DIGITS{ACTIVE_LOW}};
            end
        end
    end

    assign display = r_display;
    assign dp      = r_dp;
    assign digit   = r_digit;
    assign frame   = r_frame;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan with NUM_DIGITS=4, DIV_BITS=2, ACTIVE_LOW=1.
// The reference model counts clock edges since reset release: every 4th edge
// presents slot (edge/4 - 1) mod 4, and slot 0 starts a frame.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nums;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [6:0]  display;
    logic        dp;
    logic [3:0]  digit;
    logic        frame;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS (4),
        .DIV_BITS   (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nums       (nums),
        .load       (load),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .blink_mask (blink_mask),
        .display    (display),
        .dp         (dp),
        .digit      (digit),
        .frame      (frame)
    );

    // Glyphs (active-high, g..a) for 0-9, A, b, C, d, E, F
    logic [6:0] seg_ref [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int          n_checks;
    int          n_fail;
    int          n;
    logic [15:0] m_pend;
    logic [15:0] m_act;
    logic [3:0]  m_pend_dp;
    logic [3:0]  m_act_dp;
    logic [3:0]  e_digit;
    logic [6:0]  e_disp;
    logic        e_dp;
    logic        e_frame;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_pend    = '0;
        m_act     = '0;
        m_pend_dp = '0;
        m_act_dp  = '0;
        e_digit   = 4'hF;
        e_disp    = 7'h7F;
        e_dp      = 1'b1;
        e_frame   = 1'b0;
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge
    task automatic model_edge(input logic ld, input logic [15:0] nv, input logic [3:0] dv);
        int         slot;
        int         hi;
        bit         lit;
        bit         blink_dark;
        logic [3:0] nib;
        n++;
        e_frame = 1'b0;
        if (n % 4 == 0) begin
            slot = (n / 4 - 1) % 4;
            if (slot == 0) begin
                m_act    = ld ? nv : m_pend;
                m_act_dp = ld ? dv : m_pend_dp;
                e_frame  = 1'b1;
            end
            hi = 0;
            for (int i = 0; i < 4; i++) begin
                if (((m_act >> (4 * i)) & 16'hF) != 16'h0) hi = i;
            end
            blink_dark = 1'b0;
`ifdef SEG_BLINK_EN
            blink_dark = blink_mask[slot] && (((n - 1) % 1024) >= 512);
`endif
            lit = !blank_mask[slot] && !(lz_en && slot > hi) && !blink_dark;
            nib = 4'((m_act >> (4 * slot)) & 16'hF);
            if (lit) begin
                e_digit = ~(4'b0001 << slot);
                e_disp  = ~seg_ref[nib];
                e_dp    = ~m_act_dp[slot];
            end else begin
                e_digit = 4'hF;
                e_disp  = 7'h7F;
                e_dp    = 1'b1;
            end
        end
        if (ld) begin
            m_pend    = nv;
            m_pend_dp = dv;
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] nv, input logic [3:0] dv);
        load  = ld;
        nums  = nv;
        dp_in = dv;
        @(posedge clk);
        model_edge(ld, nv, dv);
        #1;
        check("digit",   16'(digit),   16'(e_digit));
        check("display", 16'(display), 16'(e_disp));
        check("dp",      16'(dp),      16'(e_dp));
        check("frame",   16'(frame),   16'(e_frame));
        load = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 4'h0);
    endtask

    // Step until slot s has just been presented (at least one step)
    task automatic to_slot(input int s);
        int guard;
        guard = 0;
        do begin
            idle();
            guard++;
        end while (!((n % 4 == 0) && ((n / 4 - 1) % 4 == s)) && guard < 64);
        check("to_slot_bound", 16'(guard < 64), 16'(1));
    endtask

    // Assert reset (asynchronously), check dark outputs, release on a falling edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_digit",   16'(digit),   16'(4'hF));
        check("rst_display", 16'(display), 16'(7'h7F));
        check("rst_dp",      16'(dp),      16'(1'b1));
        check("rst_frame",   16'(frame),   16'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_digit",   16'(digit),   16'(4'hF));
        check("rst_hold_display", 16'(display), 16'(7'h7F));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [6:0] exp34_disp  [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    logic [3:0] exp34_digit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int          frames;
        int          dig2_on;
        int          dp_low;
        logic        ld;
        logic [15:0] nv;
        logic [15:0] msk;

        n_checks   = 0;
        n_fail     = 0;
        load       = 1'b0;
        nums       = '0;
        dp_in      = '0;
        blank_mask = '0;
        lz_en      = 1'b0;
        blink_mask = '0;
        model_reset();

        do_reset();

        // Hex decode and scan order
        step(1'b1, 16'h12AF, 4'h0);
        to_slot(3);
        for (int s = 0; s < 4; s++) begin
            to_slot(s);
            check("hex_glyph", 16'(display), 16'(exp34_disp[s]));
            check("scan_order", 16'(digit), 16'(exp34_digit[s]));
        end

        // Loads mid-frame wait for the next frame; the later load wins
        to_slot(1);
        step(1'b1, 16'h1234, 4'h0);
        to_slot(2);
        step(1'b1, 16'h5678, 4'h0);
        to_slot(3);
        check("no_tear_old_value", 16'(display), 16'(7'b1111001));
        to_slot(0);
        check("new_frame_slot0", 16'(display), 16'(7'b0000000));
        to_slot(3);
        check("new_frame_slot3", 16'(display), 16'(7'b0010010));

        // Load coincident with the frame start is shown in that frame
        repeat (3) idle();
        step(1'b1, 16'hC0DE, 4'b0001);
        check("coincident_load", 16'(display), 16'(7'b0000110));
        check("coincident_dp", 16'(dp), 16'(1'b0));

        // Leading-zero suppression
        lz_en = 1'b1;
        step(1'b1, 16'h0050, 4'h0);
        to_slot(0);
        check("lz_slot0", 16'(display), 16'(7'b1000000));
        to_slot(1);
        check("lz_slot1", 16'(display), 16'(7'b0010010));
        to_slot(2);
        check("lz_slot2_dark", 16'(digit), 16'(4'b1111));
        to_slot(3);
        check("lz_slot3_dark", 16'(display), 16'(7'h7F));
        step(1'b1, 16'h0000, 4'h0);
        to_slot(0);
        check("lz_zero_digit", 16'(digit), 16'(4'b1110));
        check("lz_zero_glyph", 16'(display), 16'(7'b1000000));
        to_slot(1);
        check("lz_zero_slot1_dark", 16'(digit), 16'(4'b1111));
        lz_en = 1'b0;

        // Blanking, decimal point and frame rate
        blank_mask = 4'b0100;
        step(1'b1, 16'h1234, 4'b0001);
        to_slot(3);
        frames  = 0;
        dig2_on = 0;
        dp_low  = 0;
        repeat (64) begin
            idle();
            if (frame === 1'b1) frames++;
            if (digit[2] === 1'b0) dig2_on++;
            if (dp === 1'b0) dp_low++;
        end
        check("frames_in_64", 16'(frames), 16'(4));
        check("blanked_digit2", 16'(dig2_on), 16'(0));
        check("dp_low_cycles", 16'(dp_low), 16'(16));
        blank_mask = 4'b0000;

        // Reset mid-slot discards data
        step(1'b1, 16'hBEEF, 4'h0);
        to_slot(0);
        to_slot(2);
        idle();
        do_reset();
        repeat (4) idle();
        check("post_rst_digit", 16'(digit), 16'(4'b1110));
        check("post_rst_glyph", 16'(display), 16'(7'b1000000));

        // Randomized traffic
        for (int k = 0; k < 320; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                blank_mask = 4'($urandom_range(0, 15));
                lz_en      = 1'($urandom_range(0, 1));
                blink_mask = 4'($urandom_range(0, 15));
            end
            ld = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       msk = 16'hFFFF;
                1:       msk = 16'h0FFF;
                2:       msk = 16'h00FF;
                3:       msk = 16'h000F;
                default: msk = 16'h0000;
            endcase
            nv = 16'($urandom) & msk;
            step(ld, nv, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, digit count, legal range 1..8.
REQ-002 Parameter DIV_BITS, default 16, refresh-prescaler width; scan tick every 2^DIV_BITS clk cycles.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = segment/digit/dp outputs active-low, 0 = active-high.
REQ-004 clk  input  1  system clock; the only clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 nums  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 = rightmost.
REQ-007 load  input  1  capture strobe for nums/dp_in, sampled each cycle.
REQ-008 dp_in  input  NUM_DIGITS  per-digit decimal point request.
REQ-009 blank_mask  input  NUM_DIGITS  1 = force digit dark; sampled live.
REQ-010 lz_en  input  1  leading-zero suppression enable; sampled live.
REQ-011 blink_mask  input  NUM_DIGITS  per-digit blink request; used only with SEG_BLINK_EN.
REQ-012 display  output  7  segments g..a, registered.
REQ-013 dp  output  1  decimal point segment, registered.
REQ-014 digit  output  NUM_DIGITS  one-hot digit enables (polarity per ACTIVE_LOW), registered.
REQ-015 frame  output  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0.

Function
REQ-016 Prescaler: DIV_BITS-bit free-running counter; tick asserted one cycle when counter = all-ones; no derived clocks.
REQ-017 Scan index: on tick, idx increments; from NUM_DIGITS-1 wraps to 0 and frame pulses that cycle.
REQ-018 On each tick, digit, display and dp update together for the new idx; no one-scan lag between digit enable and segment data.
REQ-019 Decoder covers 0-F (0-9, A, b, C, d, E, F); every nibble value lit.
REQ-020 load=1: nums and dp_in written to pending register; last load before frame boundary wins.
REQ-021 Pending copied to active register only at frame wrap, so a frame never mixes old and new values (no tearing).
REQ-022 load coincident with frame wrap: new pending value is the one copied to active at that wrap.
REQ-023 Leading-zero suppression (lz_en=1): active digits above highest nonzero nibble dark, dp included; digit 0 never suppressed; all-zero value shows single "0".
REQ-024 blank_mask[i]=1: digit i enable deasserted for its slot; scan timing unchanged.
REQ-025 Dark digit: all segment and dp outputs at inactive level, enable inactive.
REQ-026 NUM_DIGITS=1: idx constant 0, frame pulses every tick.

Reset
REQ-027 rst asserted: prescaler 0, idx 0, pending and active registers 0, frame 0.
REQ-028 During reset, digit, display and dp at inactive level (all ones when ACTIVE_LOW=1).
REQ-029 Reset mid-frame discards pending data; after release the first tick lights digit 0 with value 0.

Configuration
REQ-030 SEG_BLINK_EN defined: 2^(DIV_BITS+8)-cycle blink counter; digit i with blink_mask[i]=1 dark during counter MSB=1; blink counter cleared by rst.
REQ-031 SEG_BLINK_EN undefined: no blink counter; blink_mask ignored; port remains for a stable interface.

Structure
REQ-032 Shared package seg_pkg holds the 16-entry hex-to-segment constant table (active-high form) and segment bit-index constants.
REQ-033 One sub-module, seg_hex_decode (combinational nibble-to-7-segment); polarity inversion applied in seven_seg_scan.

Verification (NUM_DIGITS=4, DIV_BITS=2, ACTIVE_LOW=1)
REQ-034 Reset then load nums=16'h12AF -> after one full frame, slots 0..3 show F, A, 2, 1 (display 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001); digit cycles 1110, 1101, 1011, 0111, one slot per 4 clk.
REQ-035 load 16'h1234 at slot 1, then 16'h5678 at slot 2 of the same frame -> that frame shows old value only; next frame shows 5678; 1234 never displayed.
REQ-036 lz_en=1, nums=16'h0050 -> digits 3, 2 dark (digit enable high); digits 1, 0 show 5, 0; nums=16'h0000 -> only digit 0 lit with "0".
REQ-037 blank_mask=4'b0100, dp_in=4'b0001 -> digit 2 never enabled; dp low only in slot 0; frame pulses once per 16 clk.
REQ-038 Assert rst mid-slot 2 after load of 16'hBEEF -> outputs all ones during reset; after release first tick lights digit 0 with "0".
REQ-039 SEG_BLINK_EN defined, blink_mask=4'b0001 -> digit 0 dark for 512 cycles, lit for the next 512; undefined -> digit 0 always lit.
